// File: rtl/alarm_pkg.sv
// Shared types for the multi-channel alarm siren.
// Snooze support is enabled by defining SIREN_SNOOZE_EN.
package alarm_pkg;

    localparam int TIME_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        RINGING,
        SNOOZE
    } state_t;

    typedef struct packed {
        logic [TIME_W-1:0] hour;
        logic [TIME_W-1:0] minute;
        logic [TIME_W-1:0] second;
    } alarm_time_t;

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider producing a one-cycle tick every DIV clocks.
module tick_prescaler #(
    parameter int DIV = 9000000
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt;

    assign tick = (cnt == CW'(DIV - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/multi_alarm_siren.sv
// Multi-channel alarm controller with arming, queuing and ring timeout.
// Define SIREN_SNOOZE_EN to add the SNOOZE state and snooze counter.
module multi_alarm_siren
    import alarm_pkg::*;
#(
    parameter int NUM_ALARMS   = 4,
    parameter int TICK_DIV     = 9000000,
    parameter int RING_TICKS   = 600,
    parameter int SNOOZE_TICKS = 3000,
    localparam int ID_W = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [TIME_W-1:0]            current_hour,
    input  logic [TIME_W-1:0]            current_minute,
    input  logic [TIME_W-1:0]            current_second,
    input  logic [TIME_W*NUM_ALARMS-1:0] alarm_hour,
    input  logic [TIME_W*NUM_ALARMS-1:0] alarm_minute,
    input  logic [TIME_W*NUM_ALARMS-1:0] alarm_second,
    input  logic [ID_W-1:0]              sel,
    input  logic                         alarm_btn,
    input  logic                         snooze_btn,
    output logic [NUM_ALARMS-1:0]        armed,
    output logic                         alarm_siren,
    output logic                         snoozing,
    output logic [ID_W-1:0]              ringing_id
);

    localparam int N  = NUM_ALARMS;
    localparam int RW = $clog2(RING_TICKS + 1);

    logic          tick;
    state_t        state, state_n;
    logic [N-1:0]  armed_n, pending, pending_n;
    logic [N-1:0]  match, match_prev, hit, pend_all;
    logic [N-1:0]  sel_mask, rid_mask, lo_mask;
    logic [ID_W-1:0] rid, rid_n, lo_id;
    logic [RW-1:0] ring_cnt, ring_cnt_n;
    logic          alarm_prev, alarm_press;
    alarm_time_t   now;

    tick_prescaler #(.DIV(TICK_DIV)) u_presc (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    assign now = '{hour: current_hour, minute: current_minute,
                   second: current_second};

    for (genvar g = 0; g < N; g++) begin : g_ch
        alarm_time_t at;
        assign at = '{hour:   alarm_hour[TIME_W*g +: TIME_W],
                      minute: alarm_minute[TIME_W*g +: TIME_W],
                      second: alarm_second[TIME_W*g +: TIME_W]};
        assign match[g] = armed[g] && (at == now);
    end

    // A match only fires on its first tick so a dismissed alarm stays quiet.
    assign hit         = match & ~match_prev;
    assign pend_all    = pending | hit;
    assign alarm_press = alarm_btn & ~alarm_prev;
    assign sel_mask    = N'(1) << sel;
    assign rid_mask    = N'(1) << rid;
    assign lo_mask     = N'(1) << lo_id;

    always_comb begin
        lo_id = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (pend_all[i]) lo_id = ID_W'(i);
        end
    end

`ifdef SIREN_SNOOZE_EN
    localparam int SW = $clog2(SNOOZE_TICKS + 1);

    logic          snooze_prev, snooze_press;
    logic [SW-1:0] snooze_cnt, snooze_cnt_n;

    assign snooze_press = snooze_btn & ~snooze_prev;
    assign snoozing     = (state == SNOOZE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            snooze_prev <= 1'b0;
            snooze_cnt  <= '0;
        end else begin
            snooze_cnt <= snooze_cnt_n;
            if (tick) snooze_prev <= snooze_btn;
        end
    end
`else
    logic snooze_unused;

    assign snooze_unused = snooze_btn & (SNOOZE_TICKS > 0);
    assign snoozing      = 1'b0;
`endif

    always_comb begin
        state_n    = state;
        armed_n    = armed;
        pending_n  = pending;
        rid_n      = rid;
        ring_cnt_n = ring_cnt;
`ifdef SIREN_SNOOZE_EN
        snooze_cnt_n = snooze_cnt;
`endif
        if (tick) begin
            pending_n = pend_all;
            unique case (state)
                IDLE: begin
                    if (|pend_all) begin
                        state_n    = RINGING;
                        rid_n      = lo_id;
                        pending_n  = pend_all & ~lo_mask;
                        ring_cnt_n = '0;
                    end else if (alarm_press) begin
                        armed_n   = armed ^ sel_mask;
                        pending_n = pend_all & ~(sel_mask & armed);
                    end
                end
                RINGING: begin
                    if (alarm_press) begin
                        state_n   = IDLE;
                        armed_n   = armed & ~rid_mask;
                        pending_n = pend_all & ~rid_mask;
                    end
`ifdef SIREN_SNOOZE_EN
                    else if (snooze_press) begin
                        state_n      = SNOOZE;
                        snooze_cnt_n = SW'(SNOOZE_TICKS);
                    end
`endif
                    else if (ring_cnt == RW'(RING_TICKS - 1)) begin
                        state_n = IDLE;
                    end else begin
                        ring_cnt_n = ring_cnt + RW'(1);
                    end
                end
`ifdef SIREN_SNOOZE_EN
                SNOOZE: begin
                    if (alarm_press) begin
                        state_n   = IDLE;
                        armed_n   = armed & ~rid_mask;
                        pending_n = pend_all & ~rid_mask;
                    end else if (snooze_cnt == SW'(1)) begin
                        state_n    = RINGING;
                        ring_cnt_n = '0;
                    end else begin
                        snooze_cnt_n = snooze_cnt - SW'(1);
                    end
                end
`endif
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            armed      <= '0;
            pending    <= '0;
            match_prev <= '0;
            rid        <= '0;
            ring_cnt   <= '0;
            alarm_prev <= 1'b0;
        end else begin
            state    <= state_n;
            armed    <= armed_n;
            pending  <= pending_n;
            rid      <= rid_n;
            ring_cnt <= ring_cnt_n;
            if (tick) begin
                match_prev <= match;
                alarm_prev <= alarm_btn;
            end
        end
    end

    assign alarm_siren = (state == RINGING);
    assign ringing_id  = rid;

endmodule

// File: tb/tb_multi_alarm_siren.sv
// Scoreboard bench for multi_alarm_siren.
// Tick-level reference model.
module tb_multi_alarm_siren;

  localparam int N   = 4;
  localparam int DIV = 4;
  localparam int RT  = 10;
  localparam int ST  = 5;
`ifdef SIREN_SNOOZE_EN
  localparam bit SNZ_EN = 1'b1;
`else
  localparam bit SNZ_EN = 1'b0;
`endif

  typedef struct {
    logic [N-1:0] armed;
    logic         siren;
    logic         snz;
    logic [1:0]   id;
    logic         chk_id;
  } exp_t;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [7:0]     ch = 0, cm = 0, cs = 0;
  logic [8*N-1:0] ah, am, as;
  logic [1:0]     sel = 0;
  logic           abtn = 0, sbtn = 0;
  logic [N-1:0]   armed;
  logic           siren, snoozing;
  logic [1:0]     rid;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  int         pcnt;
  bit [N-1:0] m_armed, m_pend, m_mprev;
  bit         m_aprev, m_sprev;
  bit         m_ring, m_snz, m_fresh;
  int         m_id, m_left;

  always #5 clk = ~clk;

  multi_alarm_siren #(
    .NUM_ALARMS   (N),
    .TICK_DIV     (DIV),
    .RING_TICKS   (RT),
    .SNOOZE_TICKS (ST)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .current_hour   (ch),
    .current_minute (cm),
    .current_second (cs),
    .alarm_hour     (ah),
    .alarm_minute   (am),
    .alarm_second   (as),
    .sel            (sel),
    .alarm_btn      (abtn),
    .snooze_btn     (sbtn),
    .armed          (armed),
    .alarm_siren    (siren),
    .snoozing       (snoozing),
    .ringing_id     (rid)
  );

  function automatic void m_reset();
    pcnt = 0;
    m_armed = '0;
    m_pend = '0;
    m_mprev = '0;
    m_aprev = 0;
    m_sprev = 0;
    m_ring = 0;
    m_snz = 0;
    m_id = 0;
    m_left = 0;
    m_fresh = 1;
  endfunction

  function automatic void m_tick();
    bit pa, ps;
    bit [N-1:0] mt, hit;
    pa = abtn && !m_aprev;
    ps = sbtn && !m_sprev;
    m_aprev = abtn;
    m_sprev = sbtn;
    for (int i = 0; i < N; i++)
      mt[i] = m_armed[i]
        && ah[8*i +: 8] == ch
        && am[8*i +: 8] == cm
        && as[8*i +: 8] == cs;
    hit = mt & ~m_mprev;
    m_mprev = mt;
    m_pend |= hit;
    if (!m_ring && !m_snz) begin
      if (m_pend != 0) begin
        for (int i = N - 1; i >= 0; i--)
          if (m_pend[i]) m_id = i;
        m_pend[m_id] = 0;
        m_ring = 1;
        m_left = RT;
        m_fresh = 0;
      end else if (pa) begin
        m_armed[sel] = !m_armed[sel];
        if (!m_armed[sel]) m_pend[sel] = 0;
      end
    end else if (pa) begin
      m_armed[m_id] = 0;
      m_pend[m_id] = 0;
      m_ring = 0;
      m_snz = 0;
    end else if (m_ring) begin
      if (SNZ_EN && ps) begin
        m_ring = 0;
        m_snz = 1;
        m_left = ST;
      end else begin
        m_left--;
        if (m_left == 0) m_ring = 0;
      end
    end else begin
      m_left--;
      if (m_left == 0) begin
        m_snz = 0;
        m_ring = 1;
        m_left = RT;
      end
    end
  endfunction

  function automatic void step_model();
    if (reset) m_reset();
    else if (pcnt == DIV - 1) begin
      m_tick();
      pcnt = 0;
    end else pcnt++;
  endfunction

  function automatic void push();
    exp_t e;
    e.armed = m_armed;
    e.siren = m_ring;
    e.snz = m_snz;
    e.id = 2'(m_id);
    e.chk_id = m_ring || m_snz || m_fresh;
    exp_q.push_back(e);
  endfunction

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      checks++;
      if (armed !== mon_e.armed
          || siren !== mon_e.siren
          || snoozing !== mon_e.snz
          || (mon_e.chk_id
              && rid !== mon_e.id)) begin
        errors++;
        $display(
          "FAIL outputs t=%0t armed=%b/%b siren=%b/%b snz=%b/%b id=%0d/%0d",
          $time, armed, mon_e.armed,
          siren, mon_e.siren,
          snoozing, mon_e.snz,
          rid, mon_e.id);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      step_model();
      push();
      @(negedge clk);
    end
  endtask

  task automatic ticks(input int n);
    cyc(n * DIV);
  endtask

  task automatic press_a();
    abtn = 1;
    ticks(1);
    abtn = 0;
    ticks(1);
  endtask

  task automatic press_s();
    sbtn = 1;
    ticks(1);
    sbtn = 0;
    ticks(1);
  endtask

  task automatic arm(input int c);
    sel = 2'(c);
    press_a();
  endtask

  task automatic set_time(
    input int h, input int m, input int s);
    ch = 8'(h);
    cm = 8'(m);
    cs = 8'(s);
  endtask

  task automatic set_alarm(input int c,
    input int h, input int m, input int s);
    ah[8*c +: 8] = 8'(h);
    am[8*c +: 8] = 8'(m);
    as[8*c +: 8] = 8'(s);
  endtask

  task automatic chk_reset();
    checks++;
    if (armed !== '0 || siren !== 1'b0
        || snoozing !== 1'b0
        || rid !== 2'd0) begin
      errors++;
      $display(
        "FAIL reset t=%0t armed=%b siren=%b snz=%b id=%0d",
        $time, armed, siren, snoozing, rid);
    end
  endtask

  task automatic wait_siren(input int max);
    int k;
    k = 0;
    while (siren !== 1'b1 && k < max) begin
      cyc(1);
      k++;
    end
    checks++;
    if (siren !== 1'b1) begin
      errors++;
      $display("FAIL wait siren expired t=%0t",
               $time);
    end
  endtask

  task automatic reset_mid();
    @(posedge clk);
    step_model();
    #2 reset = 1;
    m_reset();
    push();
    @(negedge clk);
    chk_reset();
    cyc(2);
    reset = 0;
  endtask

  initial begin
    for (int c = 0; c < N; c++)
      set_alarm(c, 99, 99, 99);
    m_reset();
    @(negedge clk);
    cyc(3);
    chk_reset();
    reset = 0;
    ticks(2);

    arm(2);
    arm(2);
    sel = 2;
    abtn = 1;
    ticks(20);
    abtn = 0;
    ticks(2);
    arm(2);

    set_alarm(1, 7, 30, 0);
    arm(1);
    set_time(7, 30, 0);
    wait_siren(3 * DIV);
    ticks(1);
    press_a();
    ticks(5);
    set_time(7, 31, 0);
    ticks(1);

    set_alarm(0, 8, 0, 0);
    arm(0);
    set_time(8, 0, 0);
    ticks(14);
    set_time(8, 0, 1);
    ticks(1);
    arm(0);

    set_alarm(2, 9, 0, 0);
    arm(2);
    set_time(9, 0, 0);
    ticks(2);
    press_s();
    ticks(6);
    press_s();
    ticks(1);
    press_a();
    ticks(3);

    set_alarm(0, 10, 0, 0);
    set_alarm(3, 10, 0, 0);
    arm(0);
    arm(3);
    set_time(10, 0, 0);
    ticks(2);
    press_a();
    ticks(3);
    press_a();
    ticks(2);

    set_alarm(1, 11, 0, 0);
    arm(1);
    set_time(11, 0, 0);
    ticks(3);
    reset_mid();
    ticks(3);

    for (int c = 0; c < N; c++)
      set_alarm(c, $urandom_range(1, 2),
                $urandom_range(0, 1),
                $urandom_range(0, 1));
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 2) == 0)
        set_time($urandom_range(1, 2),
                 $urandom_range(0, 1),
                 $urandom_range(0, 1));
      if ($urandom_range(0, 40) == 0)
        set_alarm($urandom_range(0, N - 1),
                  $urandom_range(1, 2),
                  $urandom_range(0, 1),
                  $urandom_range(0, 1));
      abtn = ($urandom_range(0, 5) == 0);
      sbtn = ($urandom_range(0, 5) == 0);
      sel  = 2'($urandom_range(0, N - 1));
      if ($urandom_range(0, 149) == 0)
        reset_mid();
      else ticks(1);
    end
    abtn = 0;
    sbtn = 0;
    ticks(2);
    #20;
    $display("CHECKS %0d ERRORS %0d",
             checks, errors);
    $finish;
  end

endmodule
